// File: rtl/seg_codes_pkg.sv
// Shared symbol-code and active-low 7-segment pattern tables for the encoder/decoder pair.
// seg_to_code() is the single source of truth for the pattern -> code direction.
package seg_codes_pkg;

  localparam logic [4:0] SYM_A     = 5'h00;
  localparam logic [4:0] SYM_B     = 5'h01;
  localparam logic [4:0] SYM_C     = 5'h02;
  localparam logic [4:0] SYM_D     = 5'h03;
  localparam logic [4:0] SYM_E     = 5'h04;
  localparam logic [4:0] SYM_F     = 5'h05;
  localparam logic [4:0] SYM_G     = 5'h06;
  localparam logic [4:0] SYM_H     = 5'h07;
  localparam logic [4:0] SYM_I     = 5'h08;
  localparam logic [4:0] SYM_J     = 5'h09;
  localparam logic [4:0] SYM_K     = 5'h0A;
  localparam logic [4:0] SYM_L     = 5'h0B;
  localparam logic [4:0] SYM_M     = 5'h0C;
  localparam logic [4:0] SYM_N     = 5'h0D;
  localparam logic [4:0] SYM_O     = 5'h0E;
  localparam logic [4:0] SYM_P     = 5'h0F;
  localparam logic [4:0] SYM_Q     = 5'h10;
  localparam logic [4:0] SYM_R     = 5'h11;
  localparam logic [4:0] SYM_S     = 5'h12;
  localparam logic [4:0] SYM_T     = 5'h13;
  localparam logic [4:0] SYM_U     = 5'h14;
  localparam logic [4:0] SYM_V     = 5'h15;
  localparam logic [4:0] SYM_W     = 5'h16;
  localparam logic [4:0] SYM_X     = 5'h17;
  localparam logic [4:0] SYM_Y     = 5'h18;
  localparam logic [4:0] SYM_Z     = 5'h19;
  localparam logic [4:0] SYM_SPACE = 5'h1A;
  localparam logic [4:0] SYM_DASH  = 5'h1B;
  localparam logic [4:0] SYM_3     = 5'h1C;
  localparam logic [4:0] SYM_BLANK = 5'h1F;

  // Active-low patterns: a 0 bit lights the segment.
  localparam logic [6:0] PAT_A     = 7'h08;
  localparam logic [6:0] PAT_B     = 7'h03;
  localparam logic [6:0] PAT_C     = 7'h46;
  localparam logic [6:0] PAT_D     = 7'h21;
  localparam logic [6:0] PAT_E     = 7'h06;
  localparam logic [6:0] PAT_F     = 7'h0E;
  localparam logic [6:0] PAT_G     = 7'h10;
  localparam logic [6:0] PAT_H     = 7'h0B;
  localparam logic [6:0] PAT_I     = 7'h79;
  localparam logic [6:0] PAT_J     = 7'h71;
  localparam logic [6:0] PAT_K     = 7'h09;
  localparam logic [6:0] PAT_L     = 7'h47;
  localparam logic [6:0] PAT_M     = 7'h36;
  localparam logic [6:0] PAT_N     = 7'h2B;
  localparam logic [6:0] PAT_O     = 7'h23;
  localparam logic [6:0] PAT_P     = 7'h0C;
  localparam logic [6:0] PAT_Q     = 7'h18;
  localparam logic [6:0] PAT_R     = 7'h2F;
  localparam logic [6:0] PAT_S     = 7'h12;
  localparam logic [6:0] PAT_T     = 7'h07;
  localparam logic [6:0] PAT_U     = 7'h41;
  localparam logic [6:0] PAT_V     = 7'h63;
  localparam logic [6:0] PAT_W     = 7'h1B;
  localparam logic [6:0] PAT_X     = 7'h2D;
  localparam logic [6:0] PAT_Y     = 7'h19;
  localparam logic [6:0] PAT_Z     = 7'h24;
  localparam logic [6:0] PAT_SPACE = 7'h77;
  localparam logic [6:0] PAT_DASH  = 7'h3F;
  localparam logic [6:0] PAT_3     = 7'h30;
  localparam logic [6:0] PAT_BLANK = 7'h7F;

  // Returns {valid, code}; blank maps to a valid SYM_BLANK so callers decide its fate.
  function automatic logic [5:0] seg_to_code(input logic [6:0] pat);
    logic [5:0] r;
    r = 6'h00;
    case (pat)
      PAT_A:     r = {1'b1, SYM_A};
      PAT_B:     r = {1'b1, SYM_B};
      PAT_C:     r = {1'b1, SYM_C};
      PAT_D:     r = {1'b1, SYM_D};
      PAT_E:     r = {1'b1, SYM_E};
      PAT_F:     r = {1'b1, SYM_F};
      PAT_G:     r = {1'b1, SYM_G};
      PAT_H:     r = {1'b1, SYM_H};
      PAT_I:     r = {1'b1, SYM_I};
      PAT_J:     r = {1'b1, SYM_J};
      PAT_K:     r = {1'b1, SYM_K};
      PAT_L:     r = {1'b1, SYM_L};
      PAT_M:     r = {1'b1, SYM_M};
      PAT_N:     r = {1'b1, SYM_N};
      PAT_O:     r = {1'b1, SYM_O};
      PAT_P:     r = {1'b1, SYM_P};
      PAT_Q:     r = {1'b1, SYM_Q};
      PAT_R:     r = {1'b1, SYM_R};
      PAT_S:     r = {1'b1, SYM_S};
      PAT_T:     r = {1'b1, SYM_T};
      PAT_U:     r = {1'b1, SYM_U};
      PAT_V:     r = {1'b1, SYM_V};
      PAT_W:     r = {1'b1, SYM_W};
      PAT_X:     r = {1'b1, SYM_X};
      PAT_Y:     r = {1'b1, SYM_Y};
      PAT_Z:     r = {1'b1, SYM_Z};
      PAT_SPACE: r = {1'b1, SYM_SPACE};
      PAT_DASH:  r = {1'b1, SYM_DASH};
      PAT_3:     r = {1'b1, SYM_3};
      PAT_BLANK: r = {1'b1, SYM_BLANK};
      default:   r = 6'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_sync_fifo.sv
// Small synchronous FIFO with count-based full/empty and a synchronous clear.
// The head is presented combinationally and reads as zero while empty.
module seg_sync_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Recovers 5-bit symbol codes from active-low 7-segment patterns and queues them
// behind a valid/ready FIFO, flagging and counting patterns outside the table.
module seg_pattern_decoder
  import seg_codes_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter bit DROP_BLANK = 1'b1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       seg_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       code_out,
  output logic             bad_pattern,
  output logic [ERR_W-1:0] err_cnt,
  output logic             overflow
);
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  logic [5:0] w_dec;
  logic       w_known;
  logic [4:0] w_code;
  logic       w_blank;
  logic       w_accept;
  logic       w_push;
  logic       w_bad;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;

  logic             r_bad;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_overflow;

  assign w_dec    = seg_to_code(seg_in);
  assign w_known  = w_dec[5];
  assign w_code   = w_dec[4:0];
  assign w_blank  = (seg_in == PAT_BLANK);

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_known && !(w_blank && DROP_BLANK);
  assign w_bad    = w_accept && !w_known;
  assign out_valid = !w_empty;
  assign w_pop    = out_valid && out_ready;

  seg_sync_fifo #(
    .W     (5),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (clr),
    .i_push  (w_push),
    .i_data  (w_code),
    .i_pop   (w_pop),
    .o_data  (code_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad      <= 1'b0;
      r_err_cnt  <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_bad      <= 1'b0;
      r_err_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_bad <= w_bad;
      if (w_bad && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_ONE;
      if (in_valid && !in_ready) r_overflow <= 1'b1;
    end
  end

  assign bad_pattern = r_bad;
  assign err_cnt     = r_err_cnt;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed bench for seg_pattern_decoder: a vector table for single-pattern decode
// plus hand-written sequences for blank handling, saturation, back-pressure, clear and reset.
module tb_seg_pattern_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] seg_in = 7'h7F;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] code_out;
  logic       bad_pattern;
  logic [7:0] err_cnt;
  logic       overflow;

  logic       nb_clr = 1'b0;
  logic       nb_in_valid = 1'b0;
  logic       nb_in_ready;
  logic [6:0] nb_seg_in = 7'h7F;
  logic       nb_out_valid;
  logic       nb_out_ready = 1'b0;
  logic [4:0] nb_code_out;
  logic       nb_bad_pattern;
  logic [7:0] nb_err_cnt;
  logic       nb_overflow;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  seg_pattern_decoder #(.DEPTH(4), .DROP_BLANK(1'b1), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .seg_in(seg_in),
    .out_valid(out_valid), .out_ready(out_ready), .code_out(code_out),
    .bad_pattern(bad_pattern), .err_cnt(err_cnt), .overflow(overflow)
  );

  seg_pattern_decoder #(.DEPTH(4), .DROP_BLANK(1'b0), .ERR_W(8)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .clr(nb_clr),
    .in_valid(nb_in_valid), .in_ready(nb_in_ready), .seg_in(nb_seg_in),
    .out_valid(nb_out_valid), .out_ready(nb_out_ready), .code_out(nb_code_out),
    .bad_pattern(nb_bad_pattern), .err_cnt(nb_err_cnt), .overflow(nb_overflow)
  );

  typedef struct {
    logic [6:0] seg;
    logic       exp_valid;
    logic [4:0] exp_code;
    logic       exp_bad;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [6:0] p);
    in_valid = 1'b1;
    seg_in   = p;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int exp_err;
    logic [4:0] fill_codes [4];
    logic [6:0] fill_pats [5];

    vecs[0] = '{7'h08, 1'b1, 5'h00, 1'b0};
    vecs[1] = '{7'h03, 1'b1, 5'h01, 1'b0};
    vecs[2] = '{7'h46, 1'b1, 5'h02, 1'b0};
    vecs[3] = '{7'h79, 1'b1, 5'h08, 1'b0};
    vecs[4] = '{7'h30, 1'b1, 5'h1C, 1'b0};
    vecs[5] = '{7'h3F, 1'b1, 5'h1B, 1'b0};
    vecs[6] = '{7'h55, 1'b0, 5'h00, 1'b1};
    vecs[7] = '{7'h7F, 1'b0, 5'h00, 1'b0};
    vecs[8] = '{7'h00, 1'b0, 5'h00, 1'b1};
    vecs[9] = '{7'h2D, 1'b1, 5'h17, 1'b0};
    fill_pats  = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06};
    fill_codes = '{5'h00, 5'h01, 5'h02, 5'h03};

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_code_out", code_out, 0);
    chk("rst_bad", bad_pattern, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    step();

    // Table-driven single-pattern decode with the consumer always ready
    exp_err = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_one(vecs[i].seg);
      if (vecs[i].exp_bad) exp_err++;
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) chk($sformatf("vec%0d_code", i), code_out, vecs[i].exp_code);
      chk($sformatf("vec%0d_bad", i), bad_pattern, vecs[i].exp_bad);
      chk($sformatf("vec%0d_err_cnt", i), err_cnt, exp_err);
      step();
      chk($sformatf("vec%0d_drained", i), out_valid, 0);
      chk($sformatf("vec%0d_bad_gone", i), bad_pattern, 0);
    end

    // Blank queued as 1F when not dropped
    nb_in_valid = 1'b1;
    nb_seg_in   = 7'h7F;
    step();
    nb_in_valid = 1'b0;
    chk("nb_blank_valid", nb_out_valid, 1);
    chk("nb_blank_code", nb_code_out, 5'h1F);
    chk("nb_blank_bad", nb_bad_pattern, 0);
    chk("nb_blank_err", nb_err_cnt, 0);

    // Error counter saturation
    in_valid = 1'b1;
    seg_in   = 7'h55;
    repeat (300) step();
    in_valid = 1'b0;
    chk("sat_err_cnt", err_cnt, 255);
    chk("sat_fifo_empty", out_valid, 0);
    step();
    chk("sat_err_hold", err_cnt, 255);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("sat_clr_err", err_cnt, 0);

    // Back-pressure: 5 offers into a 4-deep FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_one(fill_pats[i]);
      chk($sformatf("fill%0d_in_ready", i), in_ready, (i >= 3) ? 1'b0 : 1'b1);
      chk($sformatf("fill%0d_overflow", i), overflow, (i == 4) ? 1'b1 : 1'b0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), out_valid, 1);
      chk($sformatf("drain%0d_code", i), code_out, fill_codes[i]);
      step();
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_overflow_sticky", overflow, 1);

    // Full FIFO with simultaneous offer and pop
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_overflow", overflow, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(fill_pats[i]);
    chk("full_in_ready", in_ready, 0);
    in_valid  = 1'b1;
    seg_in    = 7'h06;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fullpop_in_ready", in_ready, 1);
    chk("fullpop_overflow", overflow, 1);
    chk("fullpop_head", code_out, 5'h01);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("fullpop_drain%0d", i), code_out, fill_codes[i]);
      step();
    end
    chk("fullpop_no_push", out_valid, 0);

    // clr with 3 queued and two errors, clr coinciding with an invalid accept
    clr = 1'b1;
    step();
    clr = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(fill_pats[i]);
    push_one(7'h55);
    push_one(7'h01);
    chk("preclr_err_cnt", err_cnt, 2);
    chk("preclr_head", code_out, 5'h00);
    in_valid = 1'b1;
    seg_in   = 7'h55;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_overflow2", overflow, 0);
    chk("clr_bad", bad_pattern, 0);
    chk("clr_in_ready", in_ready, 1);

    // Asynchronous reset mid-push
    push_one(7'h08);
    push_one(7'h55);
    in_valid = 1'b1;
    seg_in   = 7'h03;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_code_out", code_out, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_bad", bad_pattern, 0);
    in_valid = 1'b0;
    #10;
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
